pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DIV_CYCLES, default 32, number of cycles the divider occupies the E stage.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 i_stall  input  1  fetch (icache) miss; F cannot deliver this cycle.
REQ-005 d_stall  input  1  dcache miss; M cannot complete this cycle.
REQ-006 div_start  input  1  E-stage divide issued this cycle.
REQ-007 br_flush  input  1  E-stage branch mispredict; wrong-path instructions sit in F/D.
REQ-008 m_master_exc  input  1  master lane in M raises an exception.
REQ-009 m_slave_exc  input  1  slave lane in M raises an exception.
REQ-010 pc_ena, fd_ena, fd_clr, de_ena, de_clr, em_ena, em_clr  output  1 each  enable and clear for PC and the F/D, D/E and E/M registers.
REQ-011 mw_ena1, mw_ena2, mw_clr1, mw_clr2  output  1 each  per-lane enable and clear for the M/W register.
REQ-012 div_busy  output  1  divider occupies E.
REQ-013 exc_flush  output  1  one-cycle pulse when an exception flush is applied.

Function
REQ-014 Divider FSM: states IDLE, BUSY and DONE; counter width is $clog2(DIV_CYCLES+1).
REQ-015 IDLE->BUSY on div_start with no applied flush; counter loads DIV_CYCLES-1.
REQ-016 BUSY decrements the counter each cycle; BUSY->DONE when the counter is 0.
REQ-017 DONE lasts one cycle, then goes to IDLE.
REQ-018 div_start is ignored outside IDLE.
REQ-019 div_busy=1 in BUSY only.
REQ-020 ex_stall=div_busy: pc_ena, fd_ena, de_ena and em_ena=0, em_clr=1 (bubble into M), and M/W lanes advance normally.
REQ-021 mem_stall=d_stall: pc_ena, fd_ena, de_ena and em_ena=0; mw_ena1=mw_ena2=1 with mw_clr1=mw_clr2=1 (bubble into W).
REQ-022 i_stall alone: pc_ena=0, fd_ena=1, fd_clr=1 (bubble into D); D/E, E/M and M/W advance.
REQ-023 Stall priority: mem_stall > ex_stall > i_stall; only the highest active stall rule applies.
REQ-024 exc_req=m_master_exc|m_slave_exc.
REQ-025 An exc_req during mem_stall sets flag exc_pend; no flush is applied that cycle.
REQ-026 exc_pend clears in the first cycle with d_stall=0, and that cycle applies the flush.
REQ-027 A second exc_req while exc_pend=1 is absorbed (no double flush).
REQ-028 Flush applied (exc_req or exc_pend, with d_stall=0): pc_ena=1, all ena=1, fd_clr=de_clr=em_clr=1, exc_flush=1.
REQ-029 A flush overrides ex_stall and i_stall.
REQ-030 A flush forces the divider FSM to IDLE on the next edge.
REQ-031 M/W on flush: if master excepts, mw_clr1=mw_clr2=1; if only slave excepts, mw_clr1=0 (master commits) and mw_clr2=1.
REQ-032 br_flush is honoured only with no stall and no flush: fd_clr=1 and de_clr=0; the branch unit holds br_flush until honoured.
REQ-033 No event: every ena=1 and every clr=0.
REQ-034 All outputs are combinational from state and inputs; only the FSM, counter and exc_pend are registered.

Reset
REQ-035 resetn=0 asynchronously forces FSM=IDLE, counter=0 and exc_pend=0.
REQ-036 While resetn=0: every clr=1, every ena=1, pc_ena=0, div_busy=0, exc_flush=0.
REQ-037 A divide or pending flush in flight is discarded by reset.
REQ-038 The first cycle after release behaves per REQ-033.

Verification
REQ-039 div_start at cycle 0, DIV_CYCLES=32 -> div_busy=1 for cycles 1..32, em_clr=1 for those cycles, pc_ena=1 again at cycle 33.
REQ-040 d_stall high for 5 cycles with m_slave_exc pulsed in stall cycle 2 -> exc_flush=0 during the stall, exc_flush=1 for exactly one cycle when d_stall falls, mw_clr1=0, mw_clr2=1.
REQ-041 m_master_exc at BUSY counter 10 -> exc_flush=1 that cycle, div_busy=0 next cycle, mw_clr1=mw_clr2=1.
REQ-042 i_stall and d_stall together -> fd_clr=0, mw_clr1=mw_clr2=1, pc_ena=0.
REQ-043 br_flush with i_stall=1 -> no fd_clr; when i_stall drops -> fd_clr=1, de_clr=0 for one cycle.
REQ-044 resetn low mid-BUSY with exc_pend=1 -> div_busy=0 immediately, no exc_flush after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - dual-lane pipeline stall/flush controller with multi-cycle divider tracking
module pipe_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_stall,
    input  logic d_stall,
    input  logic div_start,
    input  logic br_flush,
    input  logic m_master_exc,
    input  logic m_slave_exc,
    output logic pc_ena,
    output logic fd_ena,
    output logic fd_clr,
    output logic de_ena,
    output logic de_clr,
    output logic em_ena,
    output logic em_clr,
    output logic mw_ena1,
    output logic mw_ena2,
    output logic mw_clr1,
    output logic mw_clr2,
    output logic div_busy,
    output logic exc_flush
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

    div_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          exc_pend_q, exc_pend_d;
    logic          exc_mst_q, exc_mst_d;
    logic          exc_req, flush;

    assign exc_req  = m_master_exc | m_slave_exc;
    assign flush    = resetn & ~d_stall & (exc_req | exc_pend_q);
    assign div_busy = resetn & (state_q == BUSY);

    // A deferred exception remembers whether the master lane was involved,
    // so the master result can still commit when only the slave faulted.
    always_comb begin
        exc_pend_d = exc_pend_q;
        exc_mst_d  = exc_mst_q;
        if (!d_stall) begin
            exc_pend_d = 1'b0;
            exc_mst_d  = 1'b0;
        end else if (exc_req) begin
            exc_pend_d = 1'b1;
            exc_mst_d  = exc_mst_q | m_master_exc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            exc_pend_q <= 1'b0;
            exc_mst_q  <= 1'b0;
        end else begin
            exc_pend_q <= exc_pend_d;
            exc_mst_q  <= exc_mst_d;
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (div_start) begin
                        state_q <= BUSY;
                        cnt_q   <= CW'(DIV_CYCLES - 1);
                    end
                    BUSY: if (cnt_q == '0) state_q <= DONE;
                          else             cnt_q   <= cnt_q - CW'(1);
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        pc_ena    = 1'b1;
        fd_ena    = 1'b1;
        de_ena    = 1'b1;
        em_ena    = 1'b1;
        mw_ena1   = 1'b1;
        mw_ena2   = 1'b1;
        fd_clr    = 1'b0;
        de_clr    = 1'b0;
        em_clr    = 1'b0;
        mw_clr1   = 1'b0;
        mw_clr2   = 1'b0;
        exc_flush = 1'b0;
        if (!resetn) begin
            pc_ena  = 1'b0;
            fd_clr  = 1'b1;
            de_clr  = 1'b1;
            em_clr  = 1'b1;
            mw_clr1 = 1'b1;
            mw_clr2 = 1'b1;
        end else if (d_stall) begin
            pc_ena  = 1'b0;
            fd_ena  = 1'b0;
            de_ena  = 1'b0;
            em_ena  = 1'b0;
            mw_clr1 = 1'b1;
            mw_clr2 = 1'b1;
        end else if (flush) begin
            fd_clr    = 1'b1;
            de_clr    = 1'b1;
            em_clr    = 1'b1;
            mw_clr1   = m_master_exc | exc_mst_q;
            mw_clr2   = 1'b1;
            exc_flush = 1'b1;
        end else if (div_busy) begin
            pc_ena = 1'b0;
            fd_ena = 1'b0;
            de_ena = 1'b0;
            em_ena = 1'b0;
            em_clr = 1'b1;
        end else if (i_stall) begin
            pc_ena = 1'b0;
            fd_clr = 1'b1;
        end else if (br_flush) begin
            fd_clr = 1'b1;
        end
    end
endmodule
